debounce_array: RTL and testbench

//  N-channel button debouncer with press/release/long-press event outputs.
//  - Takes raw async pushbutton pins and produces clean levels plus 1-cycle event strobes.
//  - Sits between the input pads and the user-control logic.
//  - Shares one slow `tick` strobe (ms-scale) across all channels.
//  - Successor to the single-channel debouncer: adds per-channel width, stability depth,

---
 rtl/debounce_pkg.sv | 30 +++
 rtl/debounce_chan.sv | 115 +++++++++++
 rtl/debounce_array.sv | 47 ++++
 tb/tb_debounce_array.sv | 366 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/debounce_pkg.sv
`default_nettype none
// ============================================================================
// debounce_pkg -- shared state encoding and width helpers for debounce_array
// Rev 1.0
// ============================================================================
package debounce_pkg;

  // level == state[1]
  typedef enum logic [1:0] {
    IDLE         = 2'b00,
    PRESS_PEND   = 2'b01,
    PRESSED      = 2'b11,
    RELEASE_PEND = 2'b10
  } db_state_t;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/debounce_chan.sv
`default_nettype none
// ============================================================================
// debounce_chan -- one button channel: synchroniser, debounce FSM, hold timer
// Rev 1.0
// ============================================================================
module debounce_chan
  import debounce_pkg::*;
#(
  parameter int SYNC_STAGES  = 2,
  parameter int STABLE_TICKS = 3,
  parameter int HOLD_TICKS   = 8,
  parameter int ACTIVE_LOW   = 0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick,
  input  logic btn_raw,
  output logic level,
  output logic press,
  output logic release_evt,
  output logic hold
);

  localparam int               CNT_W       = clog2(max_int(STABLE_TICKS, HOLD_TICKS) + 1);
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_TICKS - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'((HOLD_TICKS > 0) ? HOLD_TICKS - 1 : 0);
  localparam logic             HOLD_EN     = (HOLD_TICKS > 0);
  localparam logic             POL         = (ACTIVE_LOW != 0);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  db_state_t              state;
  logic [CNT_W-1:0]       cnt;
  logic [CNT_W-1:0]       hold_cnt;
  logic                   hold_done;

  // Polarity is folded in ahead of the chain so a reset chain reads "released".
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= (sync_q << 1) | SYNC_STAGES'(btn_raw ^ POL);
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      hold_cnt    <= '0;
      hold_done   <= 1'b0;
      press       <= 1'b0;
      release_evt <= 1'b0;
      hold        <= 1'b0;
    end else begin
      press       <= 1'b0;
      release_evt <= 1'b0;
      hold        <= 1'b0;
      case (state)
        IDLE: begin
          if (s) begin
            state <= PRESS_PEND;
            cnt   <= '0;
          end
        end
        PRESS_PEND: begin
          if (!s) begin
            state <= IDLE;
          end else if (tick) begin
            if (cnt == STABLE_LAST) begin
              state     <= PRESSED;
              press     <= 1'b1;
              hold_cnt  <= '0;
              hold_done <= 1'b0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        PRESSED: begin
          if (!s) begin
            state <= RELEASE_PEND;
            cnt   <= '0;
          end else if (tick && HOLD_EN && !hold_done) begin
            // hold_done stops the counter at HOLD_TICKS, so it never wraps
            if (hold_cnt == HOLD_LAST) begin
              hold      <= 1'b1;
              hold_done <= 1'b1;
            end
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        RELEASE_PEND: begin
          if (s) begin
            state <= PRESSED;
          end else if (tick) begin
            if (cnt == STABLE_LAST) begin
              state       <= IDLE;
              release_evt <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign level = state[1];

endmodule
`default_nettype wire

// File: rtl/debounce_array.sv
`default_nettype none
// ============================================================================
// debounce_array -- N independent debounced buttons sharing one sample tick
// Rev 1.0
// ============================================================================
module debounce_array
  import debounce_pkg::*;
#(
  parameter int N_CH         = 4,
  parameter int SYNC_STAGES  = 2,
  parameter int STABLE_TICKS = 3,
  parameter int HOLD_TICKS   = 8,
  parameter int ACTIVE_LOW   = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            tick,
  input  logic [N_CH-1:0] btn_raw,
  output logic [N_CH-1:0] level,
  output logic [N_CH-1:0] press,
  output logic [N_CH-1:0] release_evt, // "release" is a reserved word
  output logic [N_CH-1:0] hold,
  output logic            any_press
);

  for (genvar i = 0; i < N_CH; i++) begin : g_chan
    debounce_chan #(
      .SYNC_STAGES  (SYNC_STAGES),
      .STABLE_TICKS (STABLE_TICKS),
      .HOLD_TICKS   (HOLD_TICKS),
      .ACTIVE_LOW   (ACTIVE_LOW)
    ) u_chan (
      .clk         (clk),
      .rst_n       (rst_n),
      .tick        (tick),
      .btn_raw     (btn_raw[i]),
      .level       (level[i]),
      .press       (press[i]),
      .release_evt (release_evt[i]),
      .hold        (hold[i])
    );
  end

  assign any_press = |press;

endmodule
`default_nettype wire

// File: tb/tb_debounce_array.sv
`timescale 1ns/1ps
module tb_debounce_array;

  localparam int N = 4, SYNC = 2, STABLE = 3, HOLD = 8;

  logic         clk = 1'b0, rst_n = 1'b0, tick = 1'b0;
  logic [N-1:0] btn = '0;
  logic [N-1:0] btn_n;
  logic [N-1:0] level, press, rel, hold;
  logic [N-1:0] level_al, press_al, rel_al, hold_al;
  logic         any_press, any_press_al;

  int checks = 0, failures = 0;
  int tick_mode = 0;    // 0: every 10 clks, 1: random, 2: always high
  int mon_errs = 0;
  bit mon_en = 1'b0;
  logic [16:0] last_got, last_exp;

  assign btn_n = ~btn;

  debounce_array #(.N_CH(N), .SYNC_STAGES(SYNC), .STABLE_TICKS(STABLE),
                   .HOLD_TICKS(HOLD), .ACTIVE_LOW(0)) dut (
    .clk(clk), .rst_n(rst_n), .tick(tick), .btn_raw(btn),
    .level(level), .press(press), .release_evt(rel), .hold(hold), .any_press(any_press));

  // Active-low build fed the inverted pins: must behave identically to dut.
  debounce_array #(.N_CH(N), .SYNC_STAGES(SYNC), .STABLE_TICKS(STABLE),
                   .HOLD_TICKS(HOLD), .ACTIVE_LOW(1)) dut_al (
    .clk(clk), .rst_n(rst_n), .tick(tick), .btn_raw(btn_n),
    .level(level_al), .press(press_al), .release_evt(rel_al), .hold(hold_al),
    .any_press(any_press_al));

  initial forever #5 clk = ~clk;

  initial begin
    int ph;
    ph = 0;
    forever begin
      @(posedge clk); #1;
      case (tick_mode)
        0: begin ph = (ph + 1) % 10; tick = (ph == 0); end
        1: tick = ($urandom_range(0, 3) == 0);
        default: tick = 1'b1;
      endcase
    end
  end

  // Reference model: accepted level per channel plus a "disagreement" run
  // measured in ticks; hold is the number of ticks spent agreeing while pressed.
  bit acc[N], pend[N], hdone[N];
  int nt[N], hcnt[N];
  bit dly[N][SYNC];
  bit ms;
  logic [N-1:0] e_level = '0, e_press = '0, e_rel = '0, e_hold = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < N; c++) begin
        acc[c] = 0; pend[c] = 0; hdone[c] = 0; nt[c] = 0; hcnt[c] = 0;
        for (int k = 0; k < SYNC; k++) dly[c][k] = 0;
      end
      e_level = '0; e_press = '0; e_rel = '0; e_hold = '0;
    end else begin
      e_press = '0; e_rel = '0; e_hold = '0;
      for (int c = 0; c < N; c++) begin
        ms = dly[c][SYNC-1];
        for (int k = SYNC - 1; k > 0; k--) dly[c][k] = dly[c][k-1];
        dly[c][0] = btn[c];
        if (ms == acc[c]) begin
          if (pend[c]) pend[c] = 0;
          else if (acc[c] && tick && HOLD > 0 && !hdone[c]) begin
            hcnt[c]++;
            if (hcnt[c] == HOLD) begin e_hold[c] = 1'b1; hdone[c] = 1; end
          end
        end else if (!pend[c]) begin
          pend[c] = 1; nt[c] = 0;
        end else if (tick) begin
          nt[c]++;
          if (nt[c] == STABLE) begin
            acc[c] = !acc[c]; pend[c] = 0;
            if (acc[c]) begin e_press[c] = 1'b1; hcnt[c] = 0; hdone[c] = 0; end
            else e_rel[c] = 1'b1;
          end
        end
        e_level[c] = acc[c];
      end
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      if ({level, press, rel, hold, any_press} !== {e_level, e_press, e_rel, e_hold, |e_press}) begin
        mon_errs++;
        last_got = {level, press, rel, hold, any_press};
        last_exp = {e_level, e_press, e_rel, e_hold, |e_press};
      end
      if ({level_al, press_al, rel_al, hold_al, any_press_al} !== {e_level, e_press, e_rel, e_hold, |e_press}) begin
        mon_errs++;
        last_got = {level_al, press_al, rel_al, hold_al, any_press_al};
        last_exp = {e_level, e_press, e_rel, e_hold, |e_press};
      end
    end
  end

  task automatic run(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic test_reset();
    btn = '0;
    rst_n = 1'b0;
    run(3);
    checks++;
    if ({level, press, rel, hold, any_press} !== 17'h0) begin
      failures++;
      $display("FAIL reset_outputs got=%h required=0", {level, press, rel, hold, any_press});
    end
    checks++;
    if ({level_al, press_al, rel_al, hold_al, any_press_al} !== 17'h0) begin
      failures++;
      $display("FAIL reset_outputs_active_low got=%h required=0",
               {level_al, press_al, rel_al, hold_al, any_press_al});
    end
    @(negedge clk);
    rst_n = 1'b1;
    mon_en = 1'b1;
    run(5);
  endtask

  task automatic test_press();
    int np, nany, e0;
    np = 0; nany = 0; e0 = mon_errs;
    btn[0] = 1'b1;
    repeat (50) begin
      @(posedge clk); #1;
      if (press[0]) np++;
      if (any_press) nany++;
    end
    checks++;
    if (np !== 1) begin failures++; $display("FAIL press_count got=%0d required=1", np); end
    checks++;
    if (nany !== 1) begin failures++; $display("FAIL any_press_count got=%0d required=1", nany); end
    checks++;
    if (level[0] !== 1'b1) begin failures++; $display("FAIL press_level got=%b required=1", level[0]); end
    btn[0] = 1'b0;
    run(50);
    checks++;
    if (level[0] !== 1'b0) begin failures++; $display("FAIL release_level got=%b required=0", level[0]); end
    checks++;
    if (mon_errs !== e0) begin
      failures++;
      $display("FAIL press_model got=%0d diffs (dut=%h model=%h) required=0", mon_errs - e0, last_got, last_exp);
    end
  endtask

  task automatic test_glitch();
    int np, e0;
    np = 0; e0 = mon_errs;
    btn[1] = 1'b1;
    repeat (15) begin @(posedge clk); #1; if (press[1]) np++; end
    btn[1] = 1'b0;
    repeat (40) begin @(posedge clk); #1; if (press[1]) np++; end
    checks++;
    if (np !== 0) begin failures++; $display("FAIL glitch_press got=%0d required=0", np); end
    checks++;
    if (level[1] !== 1'b0) begin failures++; $display("FAIL glitch_level got=%b required=0", level[1]); end
    checks++;
    if (mon_errs !== e0) begin
      failures++;
      $display("FAIL glitch_model got=%0d diffs (dut=%h model=%h) required=0", mon_errs - e0, last_got, last_exp);
    end
  endtask

  task automatic test_bounce();
    int nrel, nh, lowlvl, e0;
    nrel = 0; nh = 0; lowlvl = 0; e0 = mon_errs;
    btn[2] = 1'b1;
    run(40);
    checks++;
    if (level[2] !== 1'b1) begin failures++; $display("FAIL bounce_pressed got=%b required=1", level[2]); end
    btn[2] = 1'b0;
    repeat (12) begin
      @(posedge clk); #1;
      if (rel[2]) nrel++;
      if (level[2] !== 1'b1) lowlvl++;
    end
    btn[2] = 1'b1;
    repeat (100) begin
      @(posedge clk); #1;
      if (rel[2]) nrel++;
      if (hold[2]) nh++;
      if (level[2] !== 1'b1) lowlvl++;
    end
    checks++;
    if (nrel !== 0) begin failures++; $display("FAIL bounce_release got=%0d required=0", nrel); end
    checks++;
    if (lowlvl !== 0) begin failures++; $display("FAIL bounce_level_drop got=%0d cycles required=0", lowlvl); end
    checks++;
    if (nh !== 1) begin failures++; $display("FAIL bounce_hold got=%0d required=1", nh); end
    btn[2] = 1'b0;
    run(50);
    checks++;
    if (mon_errs !== e0) begin
      failures++;
      $display("FAIL bounce_model got=%0d diffs (dut=%h model=%h) required=0", mon_errs - e0, last_got, last_exp);
    end
  endtask

  task automatic test_hold();
    int np, nh, pc, hc, nr, e0;
    np = 0; nh = 0; pc = 0; hc = 0; nr = 0; e0 = mon_errs;
    btn[3] = 1'b1;
    for (int i = 0; i < 130; i++) begin
      @(posedge clk); #1;
      if (press[3]) begin np++; pc = i; end
      if (hold[3]) begin nh++; hc = i; end
    end
    checks++;
    if (np !== 1) begin failures++; $display("FAIL hold_press got=%0d required=1", np); end
    checks++;
    if (nh !== 1) begin failures++; $display("FAIL hold_count got=%0d required=1", nh); end
    checks++;
    if (hc - pc !== 80) begin failures++; $display("FAIL hold_delay got=%0d clks required=80", hc - pc); end
    btn[3] = 1'b0;
    repeat (50) begin @(posedge clk); #1; if (rel[3]) nr++; end
    checks++;
    if (nr !== 1) begin failures++; $display("FAIL hold_release got=%0d required=1", nr); end
    checks++;
    if (level[3] !== 1'b0) begin failures++; $display("FAIL hold_level got=%b required=0", level[3]); end
    checks++;
    if (mon_errs !== e0) begin
      failures++;
      $display("FAIL hold_model got=%0d diffs (dut=%h model=%h) required=0", mon_errs - e0, last_got, last_exp);
    end
  endtask

  task automatic test_simultaneous();
    int nboth, nany, e0;
    nboth = 0; nany = 0; e0 = mon_errs;
    btn = 4'b1001;
    repeat (50) begin
      @(posedge clk); #1;
      if (press[0] && press[3]) nboth++;
      if (any_press) nany++;
    end
    checks++;
    if (nboth !== 1) begin failures++; $display("FAIL simul_both got=%0d required=1", nboth); end
    checks++;
    if (nany !== 1) begin failures++; $display("FAIL simul_any_press got=%0d required=1", nany); end
    btn = '0;
    run(50);
    checks++;
    if (level !== 4'b0000) begin failures++; $display("FAIL simul_released got=%b required=0000", level); end
    checks++;
    if (mon_errs !== e0) begin
      failures++;
      $display("FAIL simul_model got=%0d diffs (dut=%h model=%h) required=0", mon_errs - e0, last_got, last_exp);
    end
  endtask

  task automatic test_reset_mid();
    int first, tk, nrel, e0;
    first = -1; tk = 0; nrel = 0; e0 = mon_errs;
    btn[2] = 1'b1;
    run(40);
    btn[0] = 1'b1;
    run(4);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({level, press, rel, hold, any_press} !== 17'h0) begin
      failures++;
      $display("FAIL midreset_outputs got=%h required=0", {level, press, rel, hold, any_press});
    end
    checks++;
    if ({level_al, press_al, rel_al, hold_al, any_press_al} !== 17'h0) begin
      failures++;
      $display("FAIL midreset_outputs_active_low got=%h required=0",
               {level_al, press_al, rel_al, hold_al, any_press_al});
    end
    run(3);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 1; i <= 60; i++) begin
      @(posedge clk);
      if (i >= SYNC + 2 && first < 0 && tick) tk++;
      #1;
      if (press[0] && first < 0) first = i;
      if (rel[2] || rel[0]) nrel++;
    end
    checks++;
    if (first < SYNC + 2) begin failures++; $display("FAIL midreset_press_edge got=%0d required>=%0d", first, SYNC + 2); end
    checks++;
    if (tk !== STABLE) begin failures++; $display("FAIL midreset_fresh_ticks got=%0d required=%0d", tk, STABLE); end
    checks++;
    if (nrel !== 0) begin failures++; $display("FAIL midreset_spurious_release got=%0d required=0", nrel); end
    btn = '0;
    run(50);
    checks++;
    if (mon_errs !== e0) begin
      failures++;
      $display("FAIL midreset_model got=%0d diffs (dut=%h model=%h) required=0", mon_errs - e0, last_got, last_exp);
    end
  endtask

  task automatic test_active_low();
    int np;
    np = 0;
    btn[1] = 1'b1;    // active-low pin driven 0
    repeat (45) begin @(posedge clk); #1; if (press_al[1]) np++; end
    checks++;
    if (np !== 1) begin failures++; $display("FAIL active_low_press got=%0d required=1", np); end
    checks++;
    if (level_al[1] !== 1'b1) begin failures++; $display("FAIL active_low_level got=%b required=1", level_al[1]); end
    btn[1] = 1'b0;
    run(50);
    checks++;
    if (level_al[1] !== 1'b0) begin failures++; $display("FAIL active_low_release got=%b required=0", level_al[1]); end
  endtask

  task automatic test_random();
    int npress, rst_bad, e0;
    npress = 0; rst_bad = 0; e0 = mon_errs;
    tick_mode = 1;
    for (int i = 0; i < 1800; i++) begin
      @(posedge clk); #1;
      if (i == 1500) tick_mode = 2;
      if (press != '0) npress++;
      if (i == 700) begin
        rst_n = 1'b0;
        #1;
        if ({level, press, rel, hold, level_al, press_al, rel_al, hold_al} !== 32'h0) rst_bad++;
      end
      if (i == 703) rst_n = 1'b1;
      for (int c = 0; c < N; c++)
        if ($urandom_range(0, 15) == 0) btn[c] = ~btn[c];
    end
    tick_mode = 0;
    btn = '0;
    run(60);
    checks++;
    if (rst_bad !== 0) begin failures++; $display("FAIL random_reset_outputs got=%0d required=0", rst_bad); end
    checks++;
    if (npress == 0) begin failures++; $display("FAIL random_activity got=%0d presses required>0", npress); end
    checks++;
    if (mon_errs !== e0) begin
      failures++;
      $display("FAIL random_model got=%0d diffs (dut=%h model=%h) required=0", mon_errs - e0, last_got, last_exp);
    end
  endtask

  initial begin
    test_reset();
    test_press();
    test_glitch();
    test_bounce();
    test_hold();
    test_simultaneous();
    test_reset_mid();
    test_active_low();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
